// File: rtl/vedic_mult_seq_if.sv
// Handshake bundle for vedic_mult_seq: operand channel in, product channel out.
// The multiplier connects through the slave modport; the operand/product side uses master.
interface vedic_mult_seq_if #(
   parameter int WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     p;
   logic                   busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/vedic_mult_seq.sv
// Iterative WIDTH x WIDTH Urdhva-Tiryagbhyam multiplier: one 2-bit digit of b per cycle.
// Define VEDIC_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module vedic_mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   vedic_mult_seq_if.slave   bus_io
);

   localparam int DIGITS = WIDTH / 2;
   localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PPW    = WIDTH + 2;
   localparam int PW     = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [PW-1:0]      acc_q;
   logic [KW-1:0]      k_q;
   logic [PW-1:0]      p_q;
   logic               inReady_q;
   logic               outValid_q;
   logic               busy_q;

   logic [1:0]         digit_d;
   logic [PPW-1:0]     pp_d;
   logic [PW-1:0]      acc_d;
   logic [PW-1:0]      result_d;
   logic [WIDTH-1:0]   opA_d;
   logic [WIDTH-1:0]   opB_d;

   // 2x2 vedic cell: vertical and crosswise products merged with half adders.
   function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
      logic cross1;
      logic cross2;
      logic carry1;
      logic top;
      cross1 = x[1] & y[0];
      cross2 = x[0] & y[1];
      carry1 = cross1 & cross2;
      top    = x[1] & y[1];
      return {top & carry1, top ^ carry1, cross1 ^ cross2, x[0] & y[0]};
   endfunction

`ifdef VEDIC_SIGNED_EN
   logic sign_q;

   // The most negative value maps to its own bit pattern, which read unsigned is the right magnitude.
   always_comb begin
      opA_d = bus_io.a[WIDTH-1] ? (~bus_io.a + 1'b1) : bus_io.a;
      opB_d = bus_io.b[WIDTH-1] ? (~bus_io.b + 1'b1) : bus_io.b;
   end
`else
   always_comb begin
      opA_d = bus_io.a;
      opB_d = bus_io.b;
   end
`endif

   always_comb begin
      digit_d = 2'(b_q >> {k_q, 1'b0});
      pp_d    = '0;
      for (int i = 0; i < DIGITS; i++) begin
         pp_d = pp_d + (PPW'(vedic2x2(a_q[2*i +: 2], digit_d)) << (2 * i));
      end
      acc_d   = acc_q + (PW'(pp_d) << {k_q, 1'b0});
`ifdef VEDIC_SIGNED_EN
      result_d = sign_q ? (~acc_d + 1'b1) : acc_d;
`else
      result_d = acc_d;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         k_q        <= '0;
         p_q        <= '0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef VEDIC_SIGNED_EN
         sign_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus_io.in_valid) begin
                  a_q       <= opA_d;
                  b_q       <= opB_d;
                  acc_q     <= '0;
                  k_q       <= '0;
                  inReady_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= CALC;
`ifdef VEDIC_SIGNED_EN
                  sign_q    <= bus_io.a[WIDTH-1] ^ bus_io.b[WIDTH-1];
`endif
               end
            end
            CALC: begin
               acc_q <= acc_d;
               k_q   <= k_q + KW'(1);
               if (k_q == KW'(DIGITS - 1)) begin
                  p_q        <= result_d;
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               // Product and valid stay frozen until the consumer takes them.
               if (bus_io.out_ready) begin
                  outValid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               inReady_q  <= 1'b1;
               outValid_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus_io.in_ready  = inReady_q;
   assign bus_io.out_valid = outValid_q;
   assign bus_io.p         = p_q;
   assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Self-checking bench for vedic_mult_seq: WIDTH=8 directed/random checks and a WIDTH=4 exhaustive sweep.
// Honours VEDIC_SIGNED_EN for its reference model and directed table.
module tb_vedic_mult_seq;

   logic clk;
   logic rst;

   int checksTotal  = 0;
   int checksPassed = 0;

   vedic_mult_seq_if #(.WIDTH(8)) if8 ();
   vedic_mult_seq_if #(.WIDTH(4)) if4 ();

   vedic_mult_seq #(.WIDTH(8)) dut8 (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (if8)
   );

   vedic_mult_seq #(.WIDTH(4)) dut4 (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (if4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so a stuck handshake still ends the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      int         edgeNo;
   } pend_t;

   // Reference product straight from integer arithmetic, truncated to 2*w bits.
   function automatic logic [31:0] refProd(input int w, input logic [31:0] x, input logic [31:0] y);
      longint sx;
      longint sy;
      longint prod;
      longint maskIn;
      longint maskOut;
      maskIn  = (longint'(1) << w) - 1;
      maskOut = (longint'(1) << (2 * w)) - 1;
      sx = longint'(x) & maskIn;
      sy = longint'(y) & maskIn;
`ifdef VEDIC_SIGNED_EN
      if (x[w-1]) sx = sx - (longint'(1) << w);
      if (y[w-1]) sy = sy - (longint'(1) << w);
`endif
      prod = sx * sy;
      return 32'(prod & maskOut);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checksTotal++;
      if (act === exp) checksPassed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Launch one WIDTH=8 operation and wait for its product; lat counts edges after the accept edge.
   task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                                output logic [15:0] pOut, output int lat);
      checkOutput("in_ready before accept", 32'(if8.in_ready), 1);
      if8.a        = aIn;
      if8.b        = bIn;
      if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      lat = 0;
      while (!if8.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      pOut = if8.p;
   endtask

   task automatic releaseOutput();
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      if8.out_ready = 1'b0;
      checkOutput("out_valid after handshake", 32'(if8.out_valid), 0);
      checkOutput("in_ready after handshake", 32'(if8.in_ready), 1);
   endtask

   vec_t vecs[6];

   initial begin
      logic [15:0] pGot;
      logic [15:0] pExp;
      int          lat;
      bit          sawValid;
      pend_t       q[$];
      pend_t       e;
      int          idx;
      int          received;
      int          cyc;
      bit          acceptPending;

`ifdef VEDIC_SIGNED_EN
      vecs[0] = '{8'h80, 8'h80, 16'h4000};
      vecs[1] = '{8'hF9, 8'h05, 16'hFFDD};
      vecs[2] = '{8'h7F, 8'hFF, 16'hFF81};
      vecs[3] = '{8'd13, 8'd11, 16'd143};
      vecs[4] = '{8'hFF, 8'hFF, 16'h0001};
      vecs[5] = '{8'h00, 8'h80, 16'h0000};
`else
      vecs[0] = '{8'd255, 8'd255, 16'd65025};
      vecs[1] = '{8'd13,  8'd11,  16'd143};
      vecs[2] = '{8'd200, 8'd3,   16'd600};
      vecs[3] = '{8'd2,   8'd3,   16'd6};
      vecs[4] = '{8'd0,   8'd0,   16'd0};
      vecs[5] = '{8'd128, 8'd2,   16'd256};
`endif

      rst           = 1'b1;
      if8.in_valid  = 1'b0;
      if8.a         = '0;
      if8.b         = '0;
      if8.out_ready = 1'b0;
      if4.in_valid  = 1'b0;
      if4.a         = '0;
      if4.b         = '0;
      if4.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready", 32'(if8.in_ready), 1);
      checkOutput("reset out_valid", 32'(if8.out_valid), 0);
      checkOutput("reset busy", 32'(if8.busy), 0);
      checkOutput("reset p", 32'(if8.p), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, pGot, lat);
         checkOutput($sformatf("table[%0d] p", i), 32'(pGot), 32'(vecs[i].p));
         checkOutput($sformatf("table[%0d] latency", i), 32'(lat), 4);
         checkOutput($sformatf("table[%0d] busy in DONE", i), 32'(if8.busy), 1);
         releaseOutput();
      end

      // Backpressure: product held for 10 stalled cycles.
      pExp = 16'(refProd(8, 32'd200, 32'd3));
      applyStimulus(8'd200, 8'd3, pGot, lat);
      checkOutput("bp latency", 32'(lat), 4);
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp out_valid held", 32'(if8.out_valid), 1);
         checkOutput("bp p held", 32'(if8.p), 32'(pExp));
         checkOutput("bp in_ready low", 32'(if8.in_ready), 0);
         @(posedge clk); #1;
      end
      releaseOutput();

      // Reset aborts an operation in CALC.
      if8.a = 8'd100; if8.b = 8'd100; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      sawValid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (if8.out_valid) sawValid = 1'b1;
      end
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (if8.out_valid) sawValid = 1'b1;
      end
      checkOutput("abort no out_valid", 32'(sawValid), 0);
      checkOutput("abort p cleared", 32'(if8.p), 0);
      checkOutput("abort in_ready", 32'(if8.in_ready), 1);
      checkOutput("abort busy", 32'(if8.busy), 0);
      applyStimulus(8'd2, 8'd3, pGot, lat);
      checkOutput("after abort p", 32'(pGot), 6);
      releaseOutput();

      // Reset and in_valid on the same edge: operands must not be captured.
      rst = 1'b1; if8.a = 8'd9; if8.b = 8'd9; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; if8.in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst beats in_valid busy", 32'(if8.busy), 0);
      checkOutput("rst beats in_valid in_ready", 32'(if8.in_ready), 1);

      // Randomized operands with variable consumer delay.
      for (int i = 0; i < 24; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         applyStimulus(ra, rb, pGot, lat);
         checkOutput($sformatf("rand %0h*%0h p", ra, rb), 32'(pGot), refProd(8, 32'(ra), 32'(rb)));
         checkOutput("rand latency", 32'(lat), 4);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         releaseOutput();
      end

      // WIDTH=4 exhaustive back-to-back sweep with in_valid held high.
      idx = 0; received = 0; cyc = 0;
      if4.a = 4'd0; if4.b = 4'd0; if4.in_valid = 1'b1;
      acceptPending = if4.in_ready;
      while (received < 256 && cyc < 3000) begin
         @(posedge clk); cyc++; #1;
         if (acceptPending) begin
            q.push_back('{if4.a, if4.b, cyc});
            idx++;
            if (idx < 256) begin
               if4.a = 4'(idx >> 4);
               if4.b = 4'(idx);
            end else begin
               if4.in_valid = 1'b0;
            end
         end
         if (if4.out_valid) begin
            if (q.size() == 0) begin
               checkOutput("w4 pending op at output", 32'(q.size()), 1);
            end else begin
               e = q.pop_front();
               checkOutput($sformatf("w4 %0h*%0h p", e.a, e.b), 32'(if4.p), refProd(4, 32'(e.a), 32'(e.b)));
               checkOutput("w4 latency", 32'(cyc - e.edgeNo), 2);
            end
            received++;
         end
         acceptPending = if4.in_valid && if4.in_ready;
      end
      checkOutput("w4 products delivered", 32'(received), 256);
      checkOutput("w4 leftover ops", 32'(q.size()), 0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/vedic_mult_seq.md
Name: vedic_mult_seq

Overview:
- Parametrised, iterative multiplier that generalises the 4x4 combinational Urdhva-Tiryagbhyam multiplier to WIDTH x WIDTH operands.
- Each cycle it multiplies operand A by one 2-bit digit of B using 2x2 vedic cells and half-adder compression, then shift-accumulates the result.
- It uses valid/ready handshakes on both input and output. It sits between operand producers and DSP datapath consumers that need area-efficient multiplication.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4; product width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
p  output  2*WIDTH  product
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk):
  - state=IDLE; in_ready=1; out_valid=0; busy=0; p=0.
  - Internal accumulator, digit counter and operand registers are all cleared.
  - Reset mid-operation aborts the operation; no out_valid is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b, clear the accumulator, set k=0, go to CALC.
- CALC:
  - in_ready=0; busy=1.
  - Each edge: acc <= acc + ((a_reg * b_reg[2k+1:2k]) << 2k), where the WIDTH x 2 partial product is built from WIDTH/2 2x2 vedic cells; then k <= k+1.
  - When k = WIDTH/2-1: perform the final accumulation, load p with the result, go to DONE.
  - CALC lasts exactly WIDTH/2 cycles.
- DONE:
  - out_valid=1; p stable.
  - On an edge with out_ready=1: go to IDLE; out_valid drops the next cycle.
  - Otherwise hold indefinitely (backpressure). p and out_valid must not change while stalled.
- Latency: the accept edge is E0. out_valid is high after edge E(WIDTH/2) (2 cycles for WIDTH=4, 4 for WIDTH=8).
- Throughput: at best one product every WIDTH/2+2 cycles.
- Arithmetic:
  - Unsigned by default. The accumulator is 2*WIDTH bits and never overflows, since max product = (2^WIDTH-1)^2.
  - Each partial product is WIDTH+2 bits, zero-extended before shifting.
- p keeps its last value after the handshake until the next DONE load or reset.
- in_valid outside IDLE is ignored; the producer holds it until in_ready.
- out_ready while not in DONE has no effect.
- rst and in_valid on the same edge: reset wins and the operands are not captured.
- Operands a/b = 0 still take the full WIDTH/2 cycles; there is no early termination.

Optional Feature:
VEDIC_SIGNED_EN
- Defined: a and b are two's complement.
  - On accept, latch |a| and |b| (WIDTH-bit unsigned magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1)) and sign = a[WIDTH-1]^b[WIDTH-1].
  - On the CALC->DONE edge, p = sign ? -acc : acc.
  - The result is a correct 2*WIDTH-bit signed product, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2). Latency is unchanged.
- Undefined: purely unsigned operation; no sign logic is synthesised.

Test Plan:
- Reset values: WIDTH=8, assert rst 2 cycles -> in_ready=1, out_valid=0, busy=0, p=0.
- Unsigned product: a=8'd255, b=8'd255, in_valid for one cycle -> out_valid exactly 4 cycles after the accept edge with p=16'd65025. Also a=8'd13, b=8'd11 -> p=16'd143.
- Backpressure: a=8'd200, b=8'd3, out_ready=0 for 10 cycles -> out_valid and p=16'd600 held stable and in_ready=0 throughout. Then out_ready=1 -> out_valid=0 and in_ready=1 on the following cycle.
- Reset mid-CALC: accept a=8'd100, b=8'd100, assert rst 2 cycles later -> no out_valid ever asserted, p=0, in_ready=1. The next operation a=8'd2, b=8'd3 -> p=16'd6.
- Back-to-back and WIDTH=4: WIDTH=4, exhaustive sweep of all 256 a/b pairs with in_valid held high and out_ready=1 -> every p equals a*b. Products are delivered in order with no drops, each exactly 2 cycles after its accept.
- Signed (VEDIC_SIGNED_EN, WIDTH=8):
  - a=-128, b=-128 -> p=16'h4000.
  - a=-7, b=5 -> p=16'hFFDD (-35).
  - a=127, b=-1 -> p=16'hFF81.
